// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the multiplier FSM state encoding.
package fp32_pkg;
  localparam int EXP_IEEE754 = 8;
  localparam int MTS_IEEE754 = 23;
  localparam int MTS_W       = MTS_IEEE754 + 1;
  localparam int PROD_W      = 2 * MTS_W;
  localparam int CNT_W       = 5;

  // Exponent math runs in 10-bit two's complement to hold over/underflow.
  localparam logic [9:0] EXP_BIAS = 10'd127;
  localparam logic [9:0] EXP_MAX  = 10'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/fp32_mts_shiftadd.sv
// Iterative 24x24 mantissa multiplier: one multiplier bit per step, LSB first.
module fp32_mts_shiftadd
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [MTS_W-1:0]  ma,
  input  logic [MTS_W-1:0]  mb,
  output logic [PROD_W-1:0] product,
  output logic [CNT_W-1:0]  count,
  output logic              last
);
  logic [MTS_W-1:0] ma_q;
  logic [MTS_W-1:0] mb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_q    <= '0;
      mb_q    <= '0;
      product <= '0;
      count   <= '0;
    end else if (load) begin
      ma_q    <= ma;
      mb_q    <= mb;
      product <= '0;
      count   <= '0;
    end else if (step) begin
      if (mb_q[count])
        product <= product + ({{MTS_W{1'b0}}, ma_q} << count);
      count <= count + 5'd1;
    end
  end

  assign last = (count == 5'(MTS_W - 1));
endmodule

// File: rtl/fp32_seq_multiplier.sv
// Sequential FP32 multiplier: shift-add mantissa, truncating normalize, zero/denormal flush.
//   state | meaning
//   IDLE  | ready for an operand pair
//   MUL   | one multiplier bit per cycle (24 cycles)
//   NORM  | normalize, range-check and register the result
//   DONE  | result valid, waiting for out_ready
module fp32_seq_multiplier
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] Out,
  output logic        isZero,
  output logic        out_valid,
  input  logic        out_ready
);
  state_t state_q, state_d;
  logic load, step, norm_en, last;
  logic rdy_q, sign_q, zero_q, is_zero_q;
  logic [EXP_IEEE754-1:0] ea_q, eb_q;
  logic [31:0] out_q;
  logic [PROD_W-1:0] product;
  logic [CNT_W-1:0] count;
  logic [9:0] e_raw, e_norm;
  logic [MTS_IEEE754-1:0] mts;
  logic [31:0] norm_word;
  logic norm_zero;

  fp32_mts_shiftadd u_mts (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .ma      ({1'b1, A[MTS_IEEE754-1:0]}),
    .mb      ({1'b1, B[MTS_IEEE754-1:0]}),
    .product (product),
    .count   (count),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    norm_en = 1'b0;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        load    = 1'b1;
        state_d = (A[30:23] == '0 || B[30:23] == '0) ? NORM : MUL;
      end
      MUL: begin
        step = 1'b1;
        if (last) state_d = NORM;
      end
      NORM: begin
        norm_en = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Product of two [1,2) mantissas lies in [1,4): bit 47 selects the extra shift.
  always_comb begin
    e_raw     = {2'b00, ea_q} + {2'b00, eb_q} - EXP_BIAS;
    e_norm    = product[PROD_W-1] ? e_raw + 10'd1 : e_raw;
    mts       = product[PROD_W-1] ? product[46:24] : product[45:23];
    norm_word = {sign_q, e_norm[7:0], mts};
    norm_zero = 1'b0;
    if (zero_q || $signed(e_norm) <= 10'sd0) begin
      norm_word = 32'h0;
      norm_zero = 1'b1;
    end else if ($signed(e_norm) >= $signed(EXP_MAX)) begin
      norm_word = {sign_q, 8'hFF, 23'h0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      out_q     <= '0;
      is_zero_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (load) begin
        sign_q <= A[31] ^ B[31];
        ea_q   <= A[30:23];
        eb_q   <= B[30:23];
        zero_q <= (A[30:23] == '0) || (B[30:23] == '0);
      end
      if (norm_en) begin
        out_q     <= norm_word;
        is_zero_q <= norm_zero;
      end
    end
  end

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Out       = out_q;
  assign isZero    = is_zero_q;
endmodule
